shift_add_multiplier_ctrl: RTL and testbench

Sequential controller that time-shares one WIDTH-bit ripple-carry adder to compute an unsigned WIDTH×WIDTH product by shift-and-add. It accepts operands on a start strobe, runs one add/shift pair per multiplier bit, and presents a held 2·WIDTH-bit product with a one-cycle done pulse. It sits beside the lab ALU as its multi-cycle multiply path: switches drive the operands, and the product feeds the LED and hex display logic.

---
 rtl/shift_add_multiplier_ctrl_if.sv | 13 +
 rtl/shift_add_multiplier_ctrl.sv | 74 +++++++
 tb/tb_shift_add_multiplier_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_ctrl_if.sv
// shift_add_multiplier_ctrl_if: operand/start request and product/status bundle for the shift-add multiplier
interface shift_add_multiplier_ctrl_if #(parameter int WIDTH = 4);
  localparam int CW = $clog2(WIDTH) + 1;
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] product;
  logic done;
  logic busy;
  logic [CW-1:0] count;
  modport master (output start, a, b, input product, done, busy, count);
  modport slave (input start, a, b, output product, done, busy, count);
endinterface

// File: rtl/shift_add_multiplier_ctrl.sv
// shift_add_multiplier_ctrl: unsigned shift-and-add multiplier sharing one ripple-carry adder across iterations
module shift_add_multiplier_ctrl #(parameter int WIDTH = 4) (
  input logic clock,
  input logic resetn,
  shift_add_multiplier_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t state, n_state;
  logic [WIDTH-1:0] m, q, acc, n_m, n_q, n_acc, sum;
  logic c, n_c;
  logic [CW-1:0] count, n_count;
  logic [2*WIDTH-1:0] product, n_product;
  logic [WIDTH:0] cy;
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign sum[i] = acc[i] ^ m[i] ^ cy[i];
    assign cy[i+1] = (acc[i] & m[i]) | (cy[i] & (acc[i] ^ m[i]));
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      m <= '0;
      q <= '0;
      acc <= '0;
      c <= 1'b0;
      count <= '0;
      product <= '0;
    end else begin
      state <= n_state;
      m <= n_m;
      q <= n_q;
      acc <= n_acc;
      c <= n_c;
      count <= n_count;
      product <= n_product;
    end
  end
  always_comb begin
    n_state = state;
    n_m = m;
    n_q = q;
    n_acc = acc;
    n_c = c;
    n_count = count;
    n_product = product;
    unique case (state)
      IDLE: if (bus.start) begin
        n_m = bus.a;
        n_q = bus.b;
        n_acc = '0;
        n_c = 1'b0;
        n_count = '0;
        n_state = ADD;
      end
      ADD: begin
        {n_c, n_acc} = q[0] ? {cy[WIDTH], sum} : {1'b0, acc};
        n_state = SHIFT;
      end
      SHIFT: begin
        {n_c, n_acc, n_q} = {1'b0, c, acc, q[WIDTH-1:1]};
        n_count = count + 1'b1;
        n_product = (count == CW'(WIDTH - 1)) ? {c, acc, q[WIDTH-1:1]} : product;
        n_state = (count == CW'(WIDTH - 1)) ? DONE : ADD;
      end
      DONE: n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end
  assign bus.product = product;
  assign bus.done = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.count = count;
endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// tb_shift_add_multiplier_ctrl: directed vectors checked against a cycle-level arithmetic model and literal expectations
module tb_shift_add_multiplier_ctrl;
  localparam int W = 4;
  localparam int CW = $clog2(W) + 1;
  logic clock = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  shift_add_multiplier_ctrl_if #(.WIDTH(W)) bus ();
  shift_add_multiplier_ctrl #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1..2W iterating, 2W+1 done; product is plain a*b
  int ph = 0;
  bit mv = 0;
  logic [W-1:0] ma, mb;
  logic [2*W-1:0] mp;
  logic [CW-1:0] mc;
  always @(posedge clock) begin
    mv <= 1'b1;
    if (!resetn) begin
      ph <= 0;
      mp <= '0;
      mc <= '0;
    end else if (ph == 0) begin
      if (bus.start) begin
        ma <= bus.a;
        mb <= bus.b;
        mc <= '0;
        ph <= 1;
      end
    end else if (ph == 2*W+1) ph <= 0;
    else begin
      ph <= ph + 1;
      mc <= CW'(ph / 2);
      if (ph == 2*W) mp <= (2*W)'(ma) * (2*W)'(mb);
    end
    if (bus.done) pulses <= pulses + 1;
  end
  always @(negedge clock) if (mv) begin
    chk("product", 32'(bus.product), 32'(mp));
    chk("done", 32'(bus.done), 32'(ph == 2*W+1));
    chk("busy", 32'(bus.busy), 32'(ph != 0));
    chk("count", 32'(bus.count), 32'(mc));
  end

  task automatic mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp);
    int lat;
    @(negedge clock);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", 32'(lat), 32'd9);
    chk("mult_product", 32'(bus.product), 32'(exp));
  endtask

  initial begin
    int n, p0, prev, cyc;
    resetn = 1'b0;
    bus.start = 1'b1;
    bus.a = 4'd5;
    bus.b = 4'd5;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    resetn = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    mult(4'd3, 4'd5, 8'h0F);
    repeat (3) @(negedge clock);
    chk("hold_product", 32'(bus.product), 32'h0F);
    mult(4'd15, 4'd15, 8'hE1);
    mult(4'd15, 4'd1, 8'h0F);
    mult(4'd1, 4'd15, 8'h0F);
    mult(4'd0, 4'd9, 8'h00);
    mult(4'd9, 4'd0, 8'h00);
    // inputs and start changed mid-operation must not disturb the result
    @(negedge clock);
    p0 = pulses;
    bus.a = 4'd6;
    bus.b = 4'd7;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    bus.a = 4'd2;
    bus.b = 4'd2;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    chk("ignored_product", 32'(bus.product), 32'h2A);
    chk("ignored_pulses", 32'(pulses - p0), 32'd1);
    // abort a 12x12 during a SHIFT state
    bus.a = 4'd12;
    bus.b = 4'd12;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    p0 = pulses;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (12) @(negedge clock);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_pulses", 32'(pulses - p0), 32'd0);
    // back-to-back with start held high
    bus.a = 4'd2;
    bus.b = 4'd3;
    bus.start = 1'b1;
    prev = -1;
    n = 0;
    cyc = 0;
    repeat (36) begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin
        if (prev >= 0) chk("b2b_period", 32'(cyc - prev), 32'd10);
        chk("b2b_product", 32'(bus.product), 32'h06);
        prev = cyc;
        n++;
      end
    end
    chk("b2b_pulses", 32'(n >= 3), 32'd1);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("final_idle", 32'(bus.busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
